// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier for the secp256k1 field.
// R = (A * B) mod P_CONST. Uses MSB-first interleaved double-and-add,
// one multiplier bit per clock.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; A is reduced and captured with B on accept
// RUN   | 256 double-and-add steps, one multiplier bit per cycle
// DONE  | done pulse cycle; R already holds the new result
module mod_mul_seq #(
    parameter logic [255:0] P_CONST =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] A,
    input  logic [255:0] B,
    output logic         busy,
    output logic         done,
    output logic [255:0] R
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [256:0] P_EXT = {1'b0, P_CONST};

    state_t       state;
    logic [255:0] acc;
    logic [255:0] a_r;
    logic [255:0] b_r;
    logic [7:0]   cnt;

    logic [256:0] dbl;
    logic [256:0] dbl_red;
    logic [256:0] sum;
    logic [255:0] acc_next;
    logic [255:0] a_load;

    // One step: acc <- (2*acc + bit*a_r) mod p, using two conditional subtracts.
    // Both operands of each add are already below p, so one subtract suffices.
    always_comb begin
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= P_EXT) ? (dbl - P_EXT) : dbl;
        sum      = dbl_red + (b_r[cnt] ? {1'b0, a_r} : 257'd0);
        acc_next = 256'((sum >= P_EXT) ? (sum - P_EXT) : sum);
        // 2^256 < 2p, so any 256-bit A needs at most one subtraction.
        a_load   = (A >= P_CONST) ? (A - P_CONST) : A;
    end

    // Control FSM with registered busy/done/R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            R     <= '0;
            acc   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a_load;
                        b_r   <= B;
                        acc   <= '0;
                        cnt   <= 8'd255;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == 8'd0) begin
                        // Publish on the last step so R is valid during the done cycle.
                        R     <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed testbench for mod_mul_seq with hand-computed expected results.
module tb_mod_mul_seq;

    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] P_M1 =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E;
    localparam logic [255:0] ALL_ONES = {256{1'b1}};
    localparam logic [255:0] HALF_P1  = {4'h7, {55{4'hF}}, 32'h7FFFFE18};
    localparam logic [255:0] TWO_128  = {127'd0, 1'b1, 128'd0};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] A;
    logic [255:0] B;
    logic         busy;
    logic         done;
    logic [255:0] R;

    int errors = 0;
    int checks = 0;
    int lat;

    mod_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents operands at a negedge, drops start after the accepting edge,
    // and counts cycles until done is seen (bounded).
    task automatic do_mul(input logic [255:0] a, input logic [255:0] b, output int n);
        start = 1'b1;
        A     = a;
        B     = b;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 600);
        if (!done) begin
            errors++;
            $display("FAIL timeout waiting for done observed=%0d expected=257", n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_R", R, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {255'd0, busy}, 256'd0);
        chk("idle_R", R, 256'd0);

        // 1*1
        do_mul(256'd1, 256'd1, lat);
        chk("lat_1x1", 256'(lat), 256'd257);
        chk("R_1x1", R, 256'd1);
        chk("busy_in_done", {255'd0, busy}, 256'd0);
        @(negedge clk);
        chk("done_pulse_1x1", {255'd0, done}, 256'd0);

        // (p-1)^2 = 1
        do_mul(P_M1, P_M1, lat);
        chk("R_pm1_sq", R, 256'd1);
        @(negedge clk);

        // 0 * arbitrary
        do_mul(256'd0, 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, lat);
        chk("R_zero", R, 256'd0);
        @(negedge clk);

        // A >= p reduced on load: 2^256-1 - p = 0x1000003D0
        do_mul(ALL_ONES, 256'd1, lat);
        chk("R_load_red", R, 256'h1000003D0);
        @(negedge clk);

        // 2 * (p+1)/2 = 1
        do_mul(256'd2, HALF_P1, lat);
        chk("R_half", R, 256'd1);
        @(negedge clk);

        // 2^128 * 2^128 = 2^256 = 0x1000003D1 mod p
        do_mul(TWO_128, TWO_128, lat);
        chk("R_2p256", R, 256'h1000003D1);
        chk("lat_2p256", 256'(lat), 256'd257);
        @(negedge clk);

        // start held high, operands changed mid-run
        start = 1'b1;
        A     = 256'd5;
        B     = 256'd7;
        @(negedge clk);
        chk("hold_busy", {255'd0, busy}, 256'd1);
        repeat (50) @(negedge clk);
        A   = 256'd9;
        B   = 256'd11;
        lat = 51;
        while (!done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 256'(lat), 256'd257);
        chk("hold_R", R, 256'd35);
        @(negedge clk);
        chk("hold_idle_done", {255'd0, done}, 256'd0);
        chk("hold_idle_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        chk("hold_reaccept_busy", {255'd0, busy}, 256'd1);
        chk("hold_reaccept_done", {255'd0, done}, 256'd0);
        chk("hold_R_kept", R, 256'd35);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("hold2_R", R, 256'd99);
        @(negedge clk);

        // reset in the middle of RUN
        start = 1'b1;
        A     = P_M1;
        B     = P_M1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_rst_busy", {255'd0, busy}, 256'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        chk("midrst_done", {255'd0, done}, 256'd0);
        chk("midrst_R", R, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_mul(256'd3, 256'd5, lat);
        chk("lat_3x5", 256'(lat), 256'd257);
        chk("R_3x5", R, 256'd15);
        @(negedge clk);
        chk("done_pulse_3x5", {255'd0, done}, 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
